// File: rtl/bsg_fifo_rolly_pkg.sv
// Shared widths and the per-cycle operation bundle for the rolly checkpoint FIFO.
// Helpers: ptr_width (index + wrap bit), ckpt_cnt_width; rolly_op_t = qualified ops.
package bsg_fifo_rolly_pkg;

  // Index bits plus one wrap bit, so full and empty stay distinct.
  function automatic int ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

  // Count range 0..n inclusive.
  function automatic int ckpt_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef struct packed {
    logic enq;
    logic mark;
    logic commit;
    logic drop;
    logic yumi;
    logic deq;
    logic rollback;
    logic clr;
  } rolly_op_t;

endpackage

// File: rtl/bsg_fifo_rolly_ckpt_queue.sv
// Small FIFO of write-pointer checkpoints; entry 0 is always the head.
// Ports: clk_i, reset_i, clear, push, pop, ptr (push value), head, count.
module bsg_fifo_rolly_ckpt_queue
  import bsg_fifo_rolly_pkg::*;
#(
  parameter int els_p = 2,
  parameter int ptr_width_p = 3,
  localparam int cw = ckpt_cnt_width(els_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ptr_width_p-1:0] ptr,
  output logic [ptr_width_p-1:0] head,
  output logic [cw-1:0]          count
);

  logic [ptr_width_p-1:0] ent [els_p];
  logic [ptr_width_p-1:0] nxt [els_p];
  logic [cw-1:0]          widx;

  // A pop shifts everything down first, so the push slot moves too;
  // this is what makes push+pop legal when full.
  assign widx = count - cw'(pop);
  assign head = ent[0];

  always_comb begin
    nxt = ent;
    if (pop) begin
      for (int k = 0; k < els_p - 1; k++) begin
        nxt[k] = ent[k+1];
      end
    end
    if (push) begin
      for (int k = 0; k < els_p; k++) begin
        if (widx == cw'(k)) begin
          nxt[k] = ptr;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    ent <= nxt;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear) begin
      count <= '0;
    end else begin
      count <= count + cw'(push) - cw'(pop);
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_rolly_ckpt.sv
// Speculative 1r1w FIFO: epoch-checkpointed write side, rollback read side.
// Ports: v_i/data_i/ready_o enq; mark/commit/drop epochs; ckpt_count_o;
// v_o/data_o/yumi_i read; deq_v_i, rollback_v_i, clr_v_i. Sync active-high reset.
// Define BSG_FIFO_ROLLY_CKPT_ASSERT_EN for simulation checks on illegal use.
module bsg_fifo_1r1w_rolly_ckpt
  import bsg_fifo_rolly_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p = 4,
  parameter int ckpt_els_p = 2,
  parameter bit ready_THEN_valid_p = 1'b0,
  localparam int pw = ptr_width(els_p),
  localparam int iw = pw - 1,
  localparam int cw = ckpt_cnt_width(ckpt_els_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,

  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,

  input  logic               mark_v_i,
  output logic               mark_ready_o,
  input  logic               commit_v_i,
  input  logic               drop_v_i,
  output logic [cw-1:0]      ckpt_count_o,

  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,

  input  logic               deq_v_i,
  input  logic               rollback_v_i,
  input  logic               clr_v_i
);

  logic [pw-1:0]      rptr;
  logic [pw-1:0]      rcptr;
  logic [pw-1:0]      wptr;
  logic [pw-1:0]      wcptr;
  logic [width_p-1:0] mem [els_p];

  logic [pw-1:0] head;
  logic [cw-1:0] count;
  logic          empty;
  logic          full;
  logic          ckpt_full;
  rolly_op_t     op;

  logic [pw-1:0] wcptr_post;
  logic [pw-1:0] rptr_adv;
  logic [pw-1:0] rcptr_adv;
  logic [pw-1:0] mark_ptr;

  assign empty = (rptr == wcptr);
  assign full = (wptr[iw-1:0] == rcptr[iw-1:0])
              & (wptr[pw-1] != rcptr[pw-1]);
  assign ckpt_full = (count == cw'(ckpt_els_p));

  assign ready_o = ~clr_v_i & ~full;
  assign mark_ready_o = ~clr_v_i & ~drop_v_i & ~ckpt_full;
  assign ckpt_count_o = count;

  assign v_o = ~rollback_v_i & ~empty;
  assign data_o = mem[rptr[iw-1:0]];

  always_comb begin
    op = '0;
    op.enq = (ready_THEN_valid_p ? v_i : (v_i & ready_o))
           & ~clr_v_i;
    op.mark = mark_v_i & mark_ready_o;
    op.commit = commit_v_i & ~clr_v_i & (count != '0);
    op.drop = drop_v_i & ~clr_v_i;
    op.yumi = yumi_i & v_o;
    op.deq = deq_v_i & (rcptr != wcptr);
    op.rollback = rollback_v_i;
    op.clr = clr_v_i;
  end

  // Drop sees the commit result of the same cycle.
  assign wcptr_post = op.commit ? head : wcptr;
  assign rptr_adv = rptr + pw'(op.yumi);
  assign rcptr_adv = rcptr + pw'(op.deq);
  assign mark_ptr = wptr + pw'(op.enq);

  bsg_fifo_rolly_ckpt_queue #(
    .els_p(ckpt_els_p),
    .ptr_width_p(pw)
  ) ckpt_q (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .clear(op.drop | op.clr),
    .push(op.mark),
    .pop(op.commit),
    .ptr(mark_ptr),
    .head(head),
    .count(count)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr <= '0;
      rcptr <= '0;
      wptr <= '0;
      wcptr <= '0;
    end else begin
      rcptr <= rcptr_adv;
      // rollback target includes a same-cycle deq
      rptr <= op.rollback ? rcptr_adv : rptr_adv;
      if (op.clr) begin
        wptr <= rptr_adv;
        wcptr <= rptr_adv;
      end else begin
        wcptr <= wcptr_post;
        wptr <= op.drop ? wcptr_post : mark_ptr;
      end
    end
  end

  // A dropped enq still lands in memory; it sits beyond wptr and is dead.
  always_ff @(posedge clk_i) begin
    if (op.enq) begin
      mem[wptr[iw-1:0]] <= data_i;
    end
  end

`ifdef BSG_FIFO_ROLLY_CKPT_ASSERT_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (yumi_i && !v_o)
        $error("rolly: yumi without valid");
      if (deq_v_i && rcptr == wcptr)
        $error("rolly: deq past committed data");
      if (commit_v_i && count == '0)
        $error("rolly: commit with no epoch");
      if (mark_v_i && !mark_ready_o)
        $error("rolly: mark while not ready");
      if (v_i && full)
        $error("rolly: enq while full");
    end
  end
`else
  // illegal-use checks compiled out; ignore behaviour is unchanged
`endif

endmodule
